// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width and transmit sequencer state encoding
package uart_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO with registered count/full/empty and sticky overflow
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push;
    logic             pop;
    logic [AW:0]      count_n;
    // a pop frees a slot in the same cycle, so a write at full is still taken
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign count_n = count + CW'(push) - CW'(pop);
    assign rd_data = mem[rptr];
    // storage needs no reset: entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
    end
    // pointers, occupancy, flags; overflow latches until reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count_n;
            full  <= count_n == CW'(DEPTH);
            empty <= count_n == '0;
            if (wr_en && !push) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers bytes and feeds them one frame at a time to uart_tx_8n1
module uart_tx_feeder import uart_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              busy,
    output logic [BYTE_W-1:0] txbyte,
    output logic              senddata,
    input  logic              txdone
);
    tx_state_t         state;
    tx_state_t         state_n;
    logic              pop;
    logic [BYTE_W-1:0] rd_data;
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W), .AW(AW)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );
    // state register; txbyte captured only on a pop so it holds through the frame
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            txbyte <= '0;
        end else begin
            state <= state_n;
            if (pop) txbyte <= rd_data;
        end
    end
    // next state and outputs; GAP lets the transmitter settle back to idle
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        senddata = state == SEND;
        busy     = state != IDLE;
        case (state)
            IDLE: begin
                pop     = !empty;
                state_n = empty ? IDLE : SEND;
            end
            SEND: state_n = WAIT;
            WAIT: state_n = txdone ? GAP : WAIT;
            GAP:  state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed checks of buffering, ordering, pacing, full and reset behaviour
module tb_uart_tx_feeder;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       txdone = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       busy;
    logic [7:0] txbyte;
    logic       senddata;
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int b2b = 0;
    logic prev_send = 1'b0;
    logic [7:0] sent [$];
    int send_t [$];
    int done_t [$];
    logic [7:0] msg [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    uart_tx_feeder #(.DEPTH(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .txbyte   (txbyte),
        .senddata (senddata),
        .txdone   (txdone)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // record every send request and completion pulse, and catch back-to-back sends
    always @(negedge clk) begin
        if (senddata) begin
            sent.push_back(txbyte);
            send_t.push_back(cyc);
        end
        if (txdone) done_t.push_back(cyc);
        if (senddata && prev_send) b2b = b2b + 1;
        prev_send = senddata;
    end
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        resetn = 1'b0;
        wr_en = 1'b0;
        txdone = 1'b0;
        repeat (4) tick();
        resetn = 1'b1;
    endtask
    task automatic pulse_done();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
    endtask
    initial begin
        int base;
        int sb;
        int db;
        int t;
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txbyte", txbyte, 8'h00);
        base = sent.size();
        repeat (100) tick();
        chk("idle_nosend", sent.size() - base, 0);
        chk("idle_txbyte", txbyte, 8'h00);
        wr_en = 1'b1;
        wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        chk("d_count_n1", count, 1);
        chk("d_send_n1", senddata, 0);
        tick();
        chk("d_send_n2", senddata, 1);
        chk("d_txbyte_n2", txbyte, 8'h44);
        chk("d_count_n2", count, 0);
        tick();
        chk("d_send_wait", senddata, 0);
        pulse_done();
        chk("d_busy_gap", busy, 1);
        tick();
        chk("d_busy_idle", busy, 0);
        chk("d_txbyte_hold", txbyte, 8'h44);
        do_reset();
        sb = sent.size();
        db = done_t.size();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = msg[i];
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            t = 0;
            while (sent.size() <= sb + i && t < 50) begin
                tick();
                t++;
            end
            repeat (10) tick();
            pulse_done();
        end
        repeat (3) tick();
        chk("hello_n", sent.size() - sb, 5);
        if (sent.size() >= sb + 5 && done_t.size() >= db + 4) begin
            for (int i = 0; i < 5; i++) chk($sformatf("hello_byte%0d", i), sent[sb + i], msg[i]);
            for (int i = 1; i < 5; i++) chk($sformatf("hello_gap%0d", i), send_t[sb + i] - done_t[db + i - 1], 3);
        end
        chk("hello_busy", busy, 0);
        chk("hello_empty", empty, 1);
        do_reset();
        base = sent.size();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("full_count", count, 16);
        chk("full_flag", full, 1);
        chk("full_ovf0", overflow, 0);
        chk("full_inflight", sent.size() - base, 1);
        pulse_done();
        tick();
        chk("full_idle", busy, 0);
        wr_en = 1'b1;
        wr_data = 8'hA0;
        tick();
        wr_en = 1'b0;
        chk("pp_count", count, 16);
        chk("pp_ovf", overflow, 0);
        chk("pp_send", senddata, 1);
        chk("pp_txbyte", txbyte, 8'h01);
        tick();
        wr_en = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        tick();
        chk("ovf_sticky", overflow, 1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h30 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("mf_count", count, 5);
        chk("mf_busy", busy, 1);
        resetn = 1'b0;
        tick();
        chk("mf_rst_count", count, 0);
        chk("mf_rst_busy", busy, 0);
        chk("mf_rst_empty", empty, 1);
        chk("mf_rst_send", senddata, 0);
        chk("mf_rst_ovf", overflow, 0);
        resetn = 1'b1;
        base = sent.size();
        tick();
        pulse_done();
        repeat (10) tick();
        chk("mf_nosend", sent.size() - base, 0);
        chk("no_b2b_send", b2b, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
